// File: rtl/mmio_bus_initiator_if.sv
// Bus bundle for the MMIO initiator: host command channel, processor-style
// data bus (address/MemRead/MemWrite/data/read-valid) and response stream.
interface mmio_bus_initiator_if #(
    parameter int MAX_BURST = 16
);
    localparam int CW = $clog2(MAX_BURST) + 1;

    // Command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [CW-1:0] cmd_count;

    // Processor-style data bus
    logic [31:0]   address;
    logic          MemRead;
    logic          MemWrite;
    logic [31:0]   io_memory_write;
    logic [31:0]   io_memory_read;
    logic          valid_io_read;

    // Response stream
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_error;
    logic          rsp_last;

    // Initiator view
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_count,
        output cmd_ready,
        output address, MemRead, MemWrite, io_memory_write,
        input  io_memory_read, valid_io_read,
        output rsp_valid, rsp_data, rsp_error, rsp_last,
        input  rsp_ready
    );

    // Environment view: command source, bus responder, response sink
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_count,
        input  cmd_ready,
        input  address, MemRead, MemWrite, io_memory_write,
        output io_memory_read, valid_io_read,
        input  rsp_valid, rsp_data, rsp_error, rsp_last,
        output rsp_ready
    );
endinterface

// File: rtl/mmio_bus_initiator.sv
// Command-driven second master for the processor data bus. Executes
// single-word or incrementing-burst reads/writes and returns one response
// per read beat (or one per write command) on a valid/ready stream.
module mmio_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int MAX_BURST      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_bus_initiator_if.master bus
);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_RSP
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [CW-1:0] remaining_q;
    logic [CW-1:0] count_clamped;
    logic [7:0]    timer_q;
    logic          write_q;
    logic          error_q;
    logic          accept;
    logic          last_beat;
    logic          timed_out;
    logic          more_reads;

    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign last_beat  = (remaining_q == CW'(1));
    assign timed_out  = (timer_q == 8'(TIMEOUT_CYCLES));
    assign more_reads = !write_q && !last_beat && !error_q;

    // Burst length normalisation: 0 means one beat, oversize clamps.
    always_comb begin
        count_clamped = bus.cmd_count;
        if (bus.cmd_count == '0)
            count_clamped = CW'(1);
        else if (bus.cmd_count > CW'(MAX_BURST))
            count_clamped = CW'(MAX_BURST);
    end

    // State register; async reset drops the bus strobes immediately.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_last  = 1'b0;
        case (state)
            S_IDLE: begin
                // Gated by rst so cmd_ready reads 0 while reset is held.
                bus.cmd_ready = rst;
                if (accept) state_nxt = bus.cmd_write ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                bus.MemWrite = 1'b1;
                if (last_beat) state_nxt = S_RSP;
            end
            S_READ: begin
                bus.MemRead = 1'b1;
                state_nxt   = S_RWAIT;
            end
            S_RWAIT: begin
                if (bus.valid_io_read || timed_out) state_nxt = S_RSP;
            end
            S_RSP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_last  = last_beat || error_q;
                if (bus.rsp_ready) state_nxt = more_reads ? S_READ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: address/remaining bookkeeping, timeout counter, read capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            write_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q      <= bus.cmd_addr & 32'hFFFF_FFFC;
                        wdata_q     <= bus.cmd_wdata;
                        remaining_q <= count_clamped;
                        write_q     <= bus.cmd_write;
                        rdata_q     <= '0;
                        error_q     <= 1'b0;
                    end
                end
                S_WRITE: begin
                    // The final beat leaves remaining at 1 so the response reports last.
                    if (!last_beat) begin
                        addr_q      <= addr_q + 32'd4;
                        remaining_q <= remaining_q - CW'(1);
                    end
                end
                S_READ: timer_q <= '0;
                S_RWAIT: begin
                    // Data takes priority over a timeout in the same cycle.
                    if (bus.valid_io_read) begin
                        rdata_q <= bus.io_memory_read;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        error_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_RSP: begin
                    if (bus.rsp_ready && more_reads) begin
                        addr_q      <= addr_q + 32'd4;
                        remaining_q <= remaining_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.address         = addr_q;
    assign bus.io_memory_write = wdata_q;
    assign bus.rsp_data        = rdata_q;
    assign bus.rsp_error       = error_q;
endmodule

// File: doc/mmio_bus_initiator.md
# mmio_bus_initiator

Command-driven initiator for the processor-style data bus that the I/O subsystem and data memory respond to. It performs single-word or incrementing-burst reads and writes using the same signalling the processor core uses: address, MemRead, MemWrite, write data, read data and read-valid. It sits beside the processor as a debug/DMA-style second master, typically fed by a host command channel, and returns read data through a valid/ready response stream.

## Interface
- TIMEOUT_CYCLES, 15: max RWAIT cycles waiting for valid_io_read before an error response (1..255)
- MAX_BURST, 16: largest burst length in words; cmd_count width is $clog2(MAX_BURST)+1
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block can accept a command (IDLE only)
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  32  start byte address; bits [1:0] ignored, driven as 00
- cmd_wdata  input  32  write data, repeated on every beat of a write burst (fill)
- cmd_count  input  CW  beats; 0 treated as 1; values above MAX_BURST clamp to MAX_BURST
- address  output  32  bus address
- MemRead  output  1  one-cycle read strobe per read beat
- MemWrite  output  1  one-cycle write strobe per write beat
- io_memory_write  output  32  bus write data
- io_memory_read  input  32  bus read data
- valid_io_read  input  1  read data valid from responder
- rsp_valid  output  1  response beat available
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  32  read data (0 for write completions and errors)
- rsp_error  output  1  beat timed out
- rsp_last  output  1  final beat of command (or aborting error)

## Operation
- States: IDLE, WRITE, READ, RWAIT, RSP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready capture address (low bits zeroed), wdata, remaining=count (clamped, 0→1), direction; go WRITE or READ.
- WRITE: MemWrite=1, address/io_memory_write driven for one cycle per beat; address+=4, remaining-=1 each cycle; after last beat go RSP with rsp_data=0, rsp_error=0, rsp_last=1. One response per write command.
- READ: MemRead=1 for exactly one cycle; go RWAIT, clear timeout counter.
- RWAIT: MemRead=0, address held. If valid_io_read=1, capture io_memory_read, go RSP. Else count; when counter reaches TIMEOUT_CYCLES, capture 0, set error, go RSP.
- RSP: rsp_valid=1, outputs stable until rsp_ready. On handshake: read with remaining>1 and no error → address+=4, remaining-=1, READ; otherwise IDLE. rsp_last=1 when remaining==1 or error.
- Address arithmetic is modulo 2^32 (0xFFFFFFFC+4 → 0x00000000).
- valid_io_read outside RWAIT is ignored.
- Simultaneous valid_io_read and timeout in the same cycle: data wins, rsp_error=0.
- MemRead and MemWrite never both 1.

## Timing
- Reset: state IDLE; all outputs 0, including cmd_ready while rst=0; cmd_ready=1 first cycle after release. Reset mid-burst aborts immediately, bus strobes drop asynchronously, no response issued.
- Command accepted at edge 0: write beats MemWrite on cycles 1..N, rsp_valid from cycle N+1.
- Read: MemRead cycle 1; valid_io_read sampled from cycle 2; if valid at cycle 2, rsp_valid cycle 3. With rsp_ready held 1, read beats repeat every 3 cycles minimum.
- Timeout: rsp_valid TIMEOUT_CYCLES+2 cycles after MemRead with rsp_error=1.
- cmd_ready is 0 from acceptance until return to IDLE; the next command can be accepted the cycle after the final response handshake.

## Test plan
- Write addr 0x00002000, data 0xDEADBEEF, count 1 → MemWrite one cycle, address 0x00002000, io_memory_write 0xDEADBEEF; one response rsp_data=0, rsp_last=1, rsp_error=0.
- Write burst addr 0x00007F03, count 4, data 0x5 → MemWrite cycles 1–4 at 0x7F00,0x7F04,0x7F08,0x7F0C; single response.
- Read burst 3 at 0x00002000, responder returns 0x11,0x22,0x33 one cycle after each MemRead → three responses, rsp_last only on third; with rsp_ready low for 5 cycles on beat 2, data held stable and no MemRead issued.
- Read with valid_io_read never asserted, TIMEOUT_CYCLES=15, count 4 → one response at MemRead+17, rsp_error=1, rsp_data=0, rsp_last=1; return to IDLE.
- Read at 0xFFFFFFFC count 2 → second MemRead at 0x00000000; cmd_count=0 → exactly one beat.
- Assert rst=0 during beat 2 of a write burst → MemWrite drops same cycle, no response, cmd_ready=1 after release.
